// File: rtl/ab_split_fifo.sv
// rtl/ab_split_fifo.sv - splits a paired {b, a} stream into two independently drained FIFOs
// Optional feature macro AB_SPLIT_READY_THROUGH_EN: a full FIFO accepts a push on the cycle its head is popped.
module ab_split_fifo #(
    parameter int W_FIFO = 8,
    parameter int D_FIFO = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*W_FIFO-1:0]     up_data,
    input  logic                    up_valid,
    output logic                    up_ready,
    output logic [W_FIFO-1:0]       down_data_a,
    output logic                    down_valid_a,
    input  logic                    down_ready_a,
    output logic [W_FIFO-1:0]       down_data_b,
    output logic                    down_valid_b,
    input  logic                    down_ready_b,
    output logic [$clog2(D_FIFO):0] count_a,
    output logic [$clog2(D_FIFO):0] count_b
);
    localparam int AW = $clog2(D_FIFO);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W_FIFO-1:0] mem_a [D_FIFO];
    logic [W_FIFO-1:0] mem_b [D_FIFO];
    logic [AW:0]       wr_a, rd_a, wr_b, rd_b;
    logic              empty_a, empty_b, full_a, full_b;
    logic              push, pop_a, pop_b;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_a = (wr_a == rd_a);
    assign empty_b = (wr_b == rd_b);
    assign full_a  = (wr_a[AW-1:0] == rd_a[AW-1:0]) && (wr_a[AW] != rd_a[AW]);
    assign full_b  = (wr_b[AW-1:0] == rd_b[AW-1:0]) && (wr_b[AW] != rd_b[AW]);

`ifdef AB_SPLIT_READY_THROUGH_EN
    assign up_ready = !rst && (!full_a || down_ready_a) && (!full_b || down_ready_b);
`else
    assign up_ready = !rst && !full_a && !full_b;
`endif

    assign push         = up_valid && up_ready;
    assign down_valid_a = !empty_a;
    assign down_valid_b = !empty_b;
    assign pop_a        = down_valid_a && down_ready_a;
    assign pop_b        = down_valid_b && down_ready_b;
    assign down_data_a  = mem_a[rd_a[AW-1:0]];
    assign down_data_b  = mem_b[rd_b[AW-1:0]];
    assign count_a      = wr_a - rd_a;
    assign count_b      = wr_b - rd_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_a <= '0;
            rd_a <= '0;
            wr_b <= '0;
            rd_b <= '0;
        end else begin
            if (push) begin
                wr_a <= wr_a + PTR_ONE;
                wr_b <= wr_b + PTR_ONE;
            end
            if (pop_a) rd_a <= rd_a + PTR_ONE;
            if (pop_b) rd_b <= rd_b + PTR_ONE;
        end
    end

    // Storage is deliberately unreset; both halves are always written together.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_a[AW-1:0]] <= up_data[W_FIFO-1:0];
            mem_b[wr_b[AW-1:0]] <= up_data[2*W_FIFO-1:W_FIFO];
        end
    end
endmodule

// File: tb/tb_ab_split_fifo.sv
// tb/tb_ab_split_fifo.sv - randomized and directed bench for ab_split_fifo against a queue reference model
module tb_ab_split_fifo;
    localparam int W = 8;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  up_data = '0;
    logic         up_valid = 1'b0;
    logic         up_ready;
    logic [7:0]   down_data_a, down_data_b;
    logic         down_valid_a, down_valid_b;
    logic         down_ready_a = 1'b0;
    logic         down_ready_b = 1'b0;
    logic [3:0]   count_a, count_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit last_push, last_pop_a, last_pop_b;

    ab_split_fifo #(.W_FIFO(W), .D_FIFO(D)) dut (
        .clk(clk), .rst(rst),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .down_data_a(down_data_a), .down_valid_a(down_valid_a), .down_ready_a(down_ready_a),
        .down_data_b(down_data_b), .down_valid_b(down_valid_b), .down_ready_b(down_ready_b),
        .count_a(count_a), .count_b(count_b)
    );

    always #5 clk = ~clk;

    function automatic bit model_ready(bit ra, bit rb);
`ifdef AB_SPLIT_READY_THROUGH_EN
        return (qa.size() < D || ra) && (qb.size() < D || rb);
`else
        return qa.size() < D && qb.size() < D;
`endif
    endfunction

    // One clock of traffic: drive at negedge, advance the queue model at posedge, return at posedge+1.
    task automatic apply(input bit v, input logic [15:0] d, input bit ra, input bit rb);
        @(negedge clk);
        rst = 1'b0;
        up_valid = v; up_data = d; down_ready_a = ra; down_ready_b = rb;
        last_push  = v && model_ready(ra, rb);
        last_pop_a = ra && qa.size() != 0;
        last_pop_b = rb && qb.size() != 0;
        @(posedge clk);
        if (last_pop_a) void'(qa.pop_front());
        if (last_pop_b) void'(qb.pop_front());
        if (last_push) begin
            qa.push_back(d[7:0]);
            qb.push_back(d[15:8]);
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; up_valid = 1'b1; up_data = 16'h1234; down_ready_a = 1'b0; down_ready_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        qa.delete(); qb.delete();
        n_vec++; if (up_ready !== 1'b0) begin n_err++; $display("FAIL reset_up_ready got %0b exp 0", up_ready); end
        n_vec++; if ({down_valid_a, down_valid_b} !== 2'b00) begin n_err++; $display("FAIL reset_valids got %b exp 00", {down_valid_a, down_valid_b}); end
        n_vec++; if ({count_a, count_b} !== 8'h00) begin n_err++; $display("FAIL reset_counts got %0d/%0d exp 0/0", count_a, count_b); end
        @(negedge clk);
        rst = 1'b0; up_valid = 1'b0;
        #1;
        n_vec++; if (up_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_up_ready got %0b exp 1", up_ready); end
    endtask

    task automatic test_single_word();
        apply(1'b1, 16'hB7A5, 1'b0, 1'b0);
        n_vec++; if ({down_valid_a, down_valid_b} !== 2'b11) begin n_err++; $display("FAIL single_valids got %b exp 11", {down_valid_a, down_valid_b}); end
        n_vec++; if (down_data_a !== 8'hA5) begin n_err++; $display("FAIL single_data_a got %h exp a5", down_data_a); end
        n_vec++; if (down_data_b !== 8'hB7) begin n_err++; $display("FAIL single_data_b got %h exp b7", down_data_b); end
        n_vec++; if (count_a !== 4'd1 || count_b !== 4'd1) begin n_err++; $display("FAIL single_counts got %0d/%0d exp 1/1", count_a, count_b); end
        apply(1'b0, 16'h0000, 1'b1, 1'b0);
        n_vec++; if (count_a !== 4'd0 || count_b !== 4'd1) begin n_err++; $display("FAIL single_pop_a_counts got %0d/%0d exp 0/1", count_a, count_b); end
        n_vec++; if (down_valid_a !== 1'b0) begin n_err++; $display("FAIL single_pop_a_valid got %0b exp 0", down_valid_a); end
        n_vec++; if (down_data_b !== 8'hB7) begin n_err++; $display("FAIL single_hold_b got %h exp b7", down_data_b); end
        apply(1'b0, 16'h0000, 1'b0, 1'b1);
        n_vec++; if (count_b !== 4'd0) begin n_err++; $display("FAIL single_pop_b_count got %0d exp 0", count_b); end
    endtask

    task automatic test_fill_skew();
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, {8'(i + 1), 8'(i)}, 1'b1, 1'b0);
            n_vec++; if (down_data_a !== 8'(i) || count_a !== 4'd1) begin n_err++; $display("FAIL skew_a[%0d] got %h/%0d exp %h/1", i, down_data_a, count_a, 8'(i)); end
        end
        apply(1'b0, 16'h0000, 1'b1, 1'b0);
        n_vec++; if (up_ready !== 1'b0) begin n_err++; $display("FAIL skew_full_up_ready got %0b exp 0", up_ready); end
        n_vec++; if (count_a !== 4'd0 || count_b !== 4'd8) begin n_err++; $display("FAIL skew_counts got %0d/%0d exp 0/8", count_a, count_b); end
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (down_data_b !== 8'(i + 1)) begin n_err++; $display("FAIL skew_drain_b[%0d] got %h exp %h", i, down_data_b, 8'(i + 1)); end
            apply(1'b0, 16'h0000, 1'b0, 1'b1);
            if (i == 0) begin
                n_vec++; if (up_ready !== 1'b1) begin n_err++; $display("FAIL skew_ready_return got %0b exp 1", up_ready); end
            end
        end
        n_vec++; if (count_b !== 4'd0) begin n_err++; $display("FAIL skew_drained got %0d exp 0", count_b); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < D; i++) apply(1'b1, 16'($urandom), 1'b0, 1'b0);
        n_vec++; if (count_a !== 4'd8 || count_b !== 4'd8 || up_ready !== 1'b0) begin n_err++; $display("FAIL full_state got %0d/%0d rdy %0b exp 8/8 rdy 0", count_a, count_b, up_ready); end
        apply(1'b1, 16'h5AC3, 1'b1, 1'b1);
`ifdef AB_SPLIT_READY_THROUGH_EN
        n_vec++; if (count_a !== 4'd8 || count_b !== 4'd8) begin n_err++; $display("FAIL full_pop_push got %0d/%0d exp 8/8", count_a, count_b); end
`else
        n_vec++; if (count_a !== 4'd7 || count_b !== 4'd7) begin n_err++; $display("FAIL full_pop_push got %0d/%0d exp 7/7", count_a, count_b); end
`endif
        for (int k = 0; k < 20 && qa.size() != 0; k++) begin
            n_vec++; if (down_data_a !== qa[0] || down_data_b !== qb[0]) begin n_err++; $display("FAIL full_drain got %h/%h exp %h/%h", down_data_a, down_data_b, qa[0], qb[0]); end
            apply(1'b0, 16'h0000, 1'b1, 1'b1);
        end
        n_vec++; if (count_a !== 4'd0 || count_b !== 4'd0) begin n_err++; $display("FAIL full_drained got %0d/%0d exp 0/0", count_a, count_b); end
    endtask

    task automatic test_wrap();
        logic [15:0] w;
        for (int i = 0; i < 40; i++) begin
            w = 16'($urandom);
            apply(1'b1, w, 1'b1, 1'b1);
            n_vec++; if (down_data_a !== w[7:0] || down_data_b !== w[15:8]) begin n_err++; $display("FAIL wrap_data[%0d] got %h/%h exp %h/%h", i, down_data_a, down_data_b, w[7:0], w[15:8]); end
            n_vec++; if (count_a > 4'd1 || count_b > 4'd1) begin n_err++; $display("FAIL wrap_count[%0d] got %0d/%0d exp <=1", i, count_a, count_b); end
        end
        apply(1'b0, 16'h0000, 1'b1, 1'b1);
        n_vec++; if (count_a !== 4'd0 || count_b !== 4'd0) begin n_err++; $display("FAIL wrap_end got %0d/%0d exp 0/0", count_a, count_b); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) apply(1'b1, 16'($urandom), 1'b0, 1'b0);
        repeat (2) apply(1'b0, 16'h0000, 1'b0, 1'b1);
        n_vec++; if (count_a !== 4'd5 || count_b !== 4'd3) begin n_err++; $display("FAIL mid_pre got %0d/%0d exp 5/3", count_a, count_b); end
        @(negedge clk);
        rst = 1'b1; up_valid = 1'b1; up_data = 16'hDEAD; down_ready_a = 1'b0; down_ready_b = 1'b0;
        @(posedge clk);
        #1;
        qa.delete(); qb.delete();
        n_vec++; if ({down_valid_a, down_valid_b} !== 2'b00 || up_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_valids got %b rdy %0b exp 00 rdy 0", {down_valid_a, down_valid_b}, up_ready); end
        n_vec++; if (count_a !== 4'd0 || count_b !== 4'd0) begin n_err++; $display("FAIL mid_rst_counts got %0d/%0d exp 0/0", count_a, count_b); end
        apply(1'b0, 16'h0000, 1'b0, 1'b0);
        n_vec++; if ({down_valid_a, down_valid_b} !== 2'b00 || up_ready !== 1'b1) begin n_err++; $display("FAIL mid_after got %b rdy %0b exp 00 rdy 1", {down_valid_a, down_valid_b}, up_ready); end
        apply(1'b1, 16'h3C4B, 1'b0, 1'b0);
        n_vec++; if (down_data_a !== 8'h4B || down_data_b !== 8'h3C || count_a !== 4'd1) begin n_err++; $display("FAIL mid_fresh got %h/%h cnt %0d exp 4b/3c cnt 1", down_data_a, down_data_b, count_a); end
        apply(1'b0, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_soak();
        int pushed = 0;
        int cyc = 0;
        int pw, pa, pb;
        logic [15:0] d;
        pw = $urandom_range(0, 10); pa = $urandom_range(0, 20); pb = $urandom_range(0, 20);
        d = 16'($urandom);
        while ((pushed < 1000 || qa.size() != 0 || qb.size() != 0) && cyc < 40000) begin
            apply((pushed < 1000) && pw == 0, d, pa == 0, pb == 0);
            cyc++;
            if (pw > 0) pw--;
            if (last_push) begin pushed++; d = 16'($urandom); pw = $urandom_range(0, 10); end
            if (last_pop_a) pa = $urandom_range(0, 20); else if (pa > 0) pa--;
            if (last_pop_b) pb = $urandom_range(0, 20); else if (pb > 0) pb--;
            n_vec++; if (up_ready !== model_ready(down_ready_a, down_ready_b)) begin n_err++; $display("FAIL soak_up_ready cyc %0d got %0b exp %0b", cyc, up_ready, model_ready(down_ready_a, down_ready_b)); end
            n_vec++; if (down_valid_a !== (qa.size() != 0) || count_a !== 4'(qa.size())) begin n_err++; $display("FAIL soak_a_state cyc %0d got v%0b c%0d exp c%0d", cyc, down_valid_a, count_a, qa.size()); end
            n_vec++; if (down_valid_b !== (qb.size() != 0) || count_b !== 4'(qb.size())) begin n_err++; $display("FAIL soak_b_state cyc %0d got v%0b c%0d exp c%0d", cyc, down_valid_b, count_b, qb.size()); end
            if (qa.size() != 0) begin
                n_vec++; if (down_data_a !== qa[0]) begin n_err++; $display("FAIL soak_data_a cyc %0d got %h exp %h", cyc, down_data_a, qa[0]); end
            end
            if (qb.size() != 0) begin
                n_vec++; if (down_data_b !== qb[0]) begin n_err++; $display("FAIL soak_data_b cyc %0d got %h exp %h", cyc, down_data_b, qb[0]); end
            end
        end
        n_vec++; if (pushed != 1000 || qa.size() != 0 || qb.size() != 0) begin n_err++; $display("FAIL soak_timeout pushed %0d left %0d/%0d exp 1000 left 0/0", pushed, qa.size(), qb.size()); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_skew();
        test_full_pop();
        test_wrap();
        test_mid_reset();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
